ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares port A of the 64 KB system `dpram` between the tv80n CPU bus and the ESP32 SPI RAM loader. The CPU no longer has to be halted for host RAM access. The CPU keeps priority and sees its address on the port while in a memory cycle. SPI reads and writes are buffered one deep and slipped into idle bus cycles. The block sits between `tv80n`, `spi_ram_btn` and `dpram` in the `trs80` top, on the `cpuClock` domain.

## Interface
- `ADDR_BITS`, 16: RAM address width.
- `ROM_TOP`, 16'h3000: CPU writes below this address are suppressed. SPI writes are never suppressed.
- `STARVE_CYCLES`, 64: pending-SPI cycle count that triggers a CPU wait (only with `RAM_ARB_WAIT_EN`).

- `clk` in 1: `cpuClock`, the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_mreq_n`, `cpu_rd_n`, `cpu_wr_n` in 1 each: CPU bus strobes.
- `cpu_addr` in ADDR_BITS; `cpu_dout` in 8: CPU address and write data.
- `cpu_wait_n` out 1: CPU wait request. Held at 1 when `RAM_ARB_WAIT_EN` is undefined.
- `spi_wr`, `spi_rd` in 1: single-cycle request strobes, already qualified with `addr[31:24]==0` upstream.
- `spi_addr` in ADDR_BITS; `spi_wdata` in 8: SPI request address and write data.
- `spi_busy` out 1: a request is buffered or in service.
- `spi_rdata` out 8; `spi_rvalid` out 1: read result and its one-cycle valid pulse.
- `spi_overrun` out 1: sticky flag, set when a strobe arrives while `spi_busy`.
- `ram_we` out 1; `ram_addr` out ADDR_BITS; `ram_din` out 8: port-A controls.
- `ram_dout` in 8: port-A read data, registered inside `dpram`, valid one cycle after the address.

## Operation
- `cpu_mem` = `~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n)`.

State machine:
- States: `IDLE`, `CPU`, `SPI_WR`, `SPI_RD`, `SPI_RD_DATA`, `SPI_DONE`.
- `IDLE`:
  - `cpu_mem` → `CPU`.
  - Otherwise, a pending write → `SPI_WR`; a pending read → `SPI_RD`.
- `CPU` holds while `cpu_mem`; returns to `IDLE` when it drops.
- `SPI_WR` → `SPI_DONE` (1 cycle).
- `SPI_RD` → `SPI_RD_DATA` → `SPI_DONE`.
- `SPI_DONE` → `IDLE`.
- SPI states are never preempted. A CPU cycle that starts during one waits for `IDLE`.

Port mux:
- SPI states drive `ram_addr=spi_addr_q` and `ram_din=spi_wdata_q`.
- All other states, including `IDLE`, drive the CPU address and data. The CPU read path through `ram_dout` is therefore always on the CPU address outside SPI service.

CPU write:
- A CPU write arms on the first cycle where `~cpu_mreq_n & ~cpu_wr_n` and the previous cycle was not a write.
- It produces exactly one `ram_we` pulse, in the first cycle the CPU owns the port, and only if `cpu_addr >= ROM_TOP`.
- A write that arms during an SPI state is deferred, not dropped.

SPI buffer:
- A strobe while `!spi_busy` latches address, data and direction, and sets `spi_busy` the next cycle.
- A strobe while `spi_busy` is ignored and sets `spi_overrun`.
- `spi_wr` and `spi_rd` in the same cycle: the write wins and the read is ignored without setting overrun.
- `spi_busy` clears in `SPI_DONE`, so the next strobe is accepted the cycle after `SPI_DONE`.

Read data:
- `spi_rdata` is captured from `ram_dout` at the end of `SPI_RD_DATA`.
- `spi_rvalid` is high for exactly the `SPI_DONE` cycle. `spi_rdata` holds until the next read.

## Timing
- Reset values: state `IDLE`; `ram_we=0`; `spi_busy=0`; `spi_rvalid=0`; `spi_overrun=0`; `spi_rdata=0`; `cpu_wait_n=1`. `ram_addr` and `ram_din` follow the CPU inputs.
- A reset mid-operation drops the buffered request and any deferred CPU write.
- SPI write latency, strobe to `ram_we`: 2 cycles when idle.
- SPI read latency, strobe to `spi_rvalid`: 4 cycles when idle.
- The CPU sees its own address on the port at most 3 cycles after `cpu_mem` rises. The system clocking (16 `clk` per CPU clock enable) guarantees the CPU samples data later than that.
- `ram_we` is never high in two consecutive cycles for one CPU write.

## Configuration
- `RAM_ARB_WAIT_EN` defined (starvation guard):
  - A counter counts consecutive cycles with `spi_busy` and no SPI service.
  - At `STARVE_CYCLES` it drives `cpu_wait_n=0`.
  - While `cpu_wait_n=0`, SPI is granted from `CPU` even though `cpu_mem` is still high.
  - `cpu_wait_n` returns to 1 one cycle after `SPI_DONE`, after the CPU address has been back on the port for at least one cycle.
  - The counter clears on service.
- `RAM_ARB_WAIT_EN` undefined: no counter, `cpu_wait_n` tied to 1, and SPI waits indefinitely for `IDLE`.

## Test plan
- **SPI write, idle:** with the CPU idle, `spi_wr` at addr 0x4000, data 0xA5 → `ram_we` 2 cycles later with `ram_addr=0x4000` and `ram_din=0xA5`; `spi_busy` lasts 3 cycles.
- **SPI read:** `spi_rd` at 0x3C00, where the RAM model holds 0x41 → `spi_rvalid` pulses 4 cycles later with `spi_rdata=0x41`.
- **CPU write protection:**
  - CPU write to 0x2FFF for 16 cycles → no `ram_we`.
  - CPU write to 0x3000 → exactly one `ram_we`.
- **Collision:** `spi_rd` issued, then CPU read begins the next cycle → SPI completes first; the CPU address is on `ram_addr` by cycle 3 and held until `mreq_n` rises.
- **Overrun:** two `spi_wr` 1 cycle apart → the first is performed, the second is ignored, and `spi_overrun=1` until reset.
- **`RAM_ARB_WAIT_EN`, `STARVE_CYCLES=8`:** `cpu_mreq_n` held low, then `spi_wr` → `cpu_wait_n=0` 8 cycles later, write performed, `cpu_wait_n=1` one cycle after `SPI_DONE`.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares dpram port A between the tv80n CPU bus and the SPI RAM loader; CPU has priority,
// SPI requests are buffered one deep. Define RAM_ARB_WAIT_EN to add the CPU starvation guard.
module ram_port_arbiter #(
  parameter int unsigned          ADDR_BITS     = 16,
  parameter logic [ADDR_BITS-1:0] ROM_TOP       = ADDR_BITS'('h3000),
  parameter int unsigned          STARVE_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_mreq_n,
  input  logic                 cpu_rd_n,
  input  logic                 cpu_wr_n,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [7:0]           cpu_dout,
  output logic                 cpu_wait_n,
  input  logic                 spi_wr,
  input  logic                 spi_rd,
  input  logic [ADDR_BITS-1:0] spi_addr,
  input  logic [7:0]           spi_wdata,
  output logic                 spi_busy,
  output logic [7:0]           spi_rdata,
  output logic                 spi_rvalid,
  output logic                 spi_overrun,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_din,
  input  logic [7:0]           ram_dout
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] CPU         = 3'd1;
  localparam logic [2:0] SPI_WR      = 3'd2;
  localparam logic [2:0] SPI_RD      = 3'd3;
  localparam logic [2:0] SPI_RD_DATA = 3'd4;
  localparam logic [2:0] SPI_DONE    = 3'd5;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic                 cpu_mem_c;
  logic                 cpu_wr_c;
  logic                 wr_prev_q;
  logic                 arm_c;
  logic                 wr_armed_q;
  logic                 wr_fire_c;
  logic                 spi_strobe_c;
  logic                 spi_accept_c;
  logic                 spi_dir_wr_q;
  logic [ADDR_BITS-1:0] spi_addr_q;
  logic [7:0]           spi_wdata_q;
  logic                 spi_port_c;
  logic                 serving_c;
  logic                 starve_c;

  assign cpu_mem_c    = ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n);
  assign cpu_wr_c     = ~cpu_mreq_n & ~cpu_wr_n;
  assign arm_c        = cpu_wr_c & ~wr_prev_q;
  assign spi_strobe_c = spi_wr | spi_rd;
  assign spi_accept_c = spi_strobe_c & ~spi_busy;
  assign spi_port_c   = (state == SPI_WR) | (state == SPI_RD) | (state == SPI_RD_DATA);
  assign serving_c    = spi_port_c | (state == SPI_DONE);
  // A CPU write fires once, on the cycle the CPU takes (or retakes) the port
  assign wr_fire_c    = (state_nxt == CPU) & (wr_armed_q | arm_c);

  // SPI_DONE already returns the port to the CPU so its address is back early
  assign ram_addr = spi_port_c ? spi_addr_q  : cpu_addr;
  assign ram_din  = spi_port_c ? spi_wdata_q : cpu_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (spi_busy && (!cpu_mem_c || starve_c)) state_nxt = spi_dir_wr_q ? SPI_WR : SPI_RD;
        else if (cpu_mem_c)                       state_nxt = CPU;
      end
      CPU: begin
        if (starve_c && spi_busy) state_nxt = spi_dir_wr_q ? SPI_WR : SPI_RD;
        else if (!cpu_mem_c)      state_nxt = IDLE;
      end
      SPI_WR:      state_nxt = SPI_DONE;
      SPI_RD:      state_nxt = SPI_RD_DATA;
      SPI_RD_DATA: state_nxt = SPI_DONE;
      SPI_DONE:    state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // CPU write arming and port write strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_q  <= 1'b0;
      wr_armed_q <= 1'b0;
      ram_we     <= 1'b0;
    end else begin
      wr_prev_q <= cpu_wr_c;
      if (wr_fire_c)  wr_armed_q <= 1'b0;
      else if (arm_c) wr_armed_q <= 1'b1;
      ram_we <= (state_nxt == SPI_WR) | (wr_fire_c & (cpu_addr >= ROM_TOP));
    end
  end

  // One-deep SPI request buffer and read return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_busy     <= 1'b0;
      spi_dir_wr_q <= 1'b0;
      spi_addr_q   <= '0;
      spi_wdata_q  <= '0;
      spi_overrun  <= 1'b0;
      spi_rdata    <= '0;
      spi_rvalid   <= 1'b0;
    end else begin
      if (spi_accept_c) begin
        spi_busy     <= 1'b1;
        spi_dir_wr_q <= spi_wr;
        spi_addr_q   <= spi_addr;
        spi_wdata_q  <= spi_wdata;
      end else if (state == SPI_DONE) begin
        spi_busy <= 1'b0;
      end
      if (spi_strobe_c && spi_busy) spi_overrun <= 1'b1;
      if (state == SPI_RD_DATA)     spi_rdata   <= ram_dout;
      spi_rvalid <= (state == SPI_RD_DATA);
    end
  end

`ifdef RAM_ARB_WAIT_EN
  localparam int unsigned CNT_W = $clog2(STARVE_CYCLES + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             wait_n_q;
  logic             starve_hit_c;

  // Counter starts at 1 on accept so the strobe cycle counts as pending
  assign starve_hit_c = (32'(starve_cnt) + 32'd1) >= STARVE_CYCLES;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      wait_n_q   <= 1'b1;
    end else begin
      if (spi_accept_c)                         starve_cnt <= CNT_W'(1);
      else if (!spi_busy || serving_c)          starve_cnt <= '0;
      else if (32'(starve_cnt) < STARVE_CYCLES) starve_cnt <= starve_cnt + CNT_W'(1);
      if (state == SPI_DONE)                                wait_n_q <= 1'b1;
      else if (spi_busy && !serving_c && starve_hit_c)      wait_n_q <= 1'b0;
    end
  end

  assign starve_c   = ~wait_n_q;
  assign cpu_wait_n = wait_n_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^32'(STARVE_CYCLES);
  assign starve_c   = 1'b0;
  assign cpu_wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural dpram port-A model.
// Covers the RAM_ARB_WAIT_EN starvation guard when that macro is defined.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wait_n;
  logic        spi_wr, spi_rd;
  logic [15:0] spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_busy;
  logic [7:0]  spi_rdata;
  logic        spi_rvalid;
  logic        spi_overrun;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = 8'h00;

  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          we_cnt;

  ram_port_arbiter #(
    .ADDR_BITS    (16),
    .ROM_TOP      (16'h3000),
    .STARVE_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_wait_n (cpu_wait_n),
    .spi_wr     (spi_wr),
    .spi_rd     (spi_rd),
    .spi_addr   (spi_addr),
    .spi_wdata  (spi_wdata),
    .spi_busy   (spi_busy),
    .spi_rdata  (spi_rdata),
    .spi_rvalid (spi_rvalid),
    .spi_overrun(spi_overrun),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // dpram port A: registered read, read-before-write
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h3C00] = 8'h41;
    mem[16'h2FFF] = 8'hEE;
    mem[16'h4200] = 8'h99;

    reset_n = 1'b0;
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    cpu_addr = 16'h1234; cpu_dout = 8'h5A;
    spi_wr = 1'b0; spi_rd = 1'b0; spi_addr = 16'h0000; spi_wdata = 8'h00;
    tick(); tick();
    check("rst_ram_we",  32'(ram_we), 32'd0);
    check("rst_busy",    32'(spi_busy), 32'd0);
    check("rst_rvalid",  32'(spi_rvalid), 32'd0);
    check("rst_overrun", 32'(spi_overrun), 32'd0);
    check("rst_rdata",   32'(spi_rdata), 32'h00);
    check("rst_wait_n",  32'(cpu_wait_n), 32'd1);
    check("rst_addr",    32'(ram_addr), 32'h1234);
    check("rst_din",     32'(ram_din), 32'h5A);
    reset_n = 1'b1;
    tick(); tick();

    // SPI write while idle: ram_we two cycles after the strobe
    spi_wr = 1'b1; spi_addr = 16'h4000; spi_wdata = 8'hA5;
    tick(); spi_wr = 1'b0;
    check("wr_c1_busy", 32'(spi_busy), 32'd1);
    check("wr_c1_we",   32'(ram_we), 32'd0);
    tick();
    check("wr_c2_we",   32'(ram_we), 32'd1);
    check("wr_c2_addr", 32'(ram_addr), 32'h4000);
    check("wr_c2_din",  32'(ram_din), 32'hA5);
    check("wr_c2_busy", 32'(spi_busy), 32'd1);
    tick();
    check("wr_c3_we",   32'(ram_we), 32'd0);
    check("wr_c3_busy", 32'(spi_busy), 32'd1);
    tick();
    check("wr_c4_busy", 32'(spi_busy), 32'd0);
    check("wr_mem",     32'(mem[16'h4000]), 32'hA5);

    // SPI read: rvalid four cycles after the strobe
    spi_rd = 1'b1; spi_addr = 16'h3C00;
    tick(); spi_rd = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check("rd_rvalid_early", 32'(spi_rvalid), 32'd0);
      tick();
    end
    check("rd_c4_rvalid", 32'(spi_rvalid), 32'd1);
    check("rd_c4_rdata",  32'(spi_rdata), 32'h41);
    tick();
    check("rd_c5_rvalid", 32'(spi_rvalid), 32'd0);
    check("rd_c5_hold",   32'(spi_rdata), 32'h41);
    tick();

    // CPU write below ROM_TOP is suppressed
    cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = 16'h2FFF; cpu_dout = 8'h77;
    we_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (ram_we) we_cnt++;
    end
    check("rom_we_count", 32'(we_cnt), 32'd0);
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    tick(); tick();
    check("rom_mem", 32'(mem[16'h2FFF]), 32'hEE);

    // CPU write at ROM_TOP: exactly one pulse
    cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = 16'h3000; cpu_dout = 8'h88;
    we_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (ram_we) we_cnt++;
    end
    check("ram_we_count", 32'(we_cnt), 32'd1);
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    tick(); tick();
    check("ram_mem", 32'(mem[16'h3000]), 32'h88);

    // Collision: SPI read in service, CPU read starts, SPI finishes first
    spi_rd = 1'b1; spi_addr = 16'h4000;
    tick(); spi_rd = 1'b0;
    tick();
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 16'h5555;
    check("col_c2_addr", 32'(ram_addr), 32'h4000);
    tick(); tick();
    check("col_rvalid", 32'(spi_rvalid), 32'd1);
    check("col_rdata",  32'(spi_rdata), 32'hA5);
    tick();
    for (int c = 0; c < 6; c++) begin
      check("col_cpu_addr", 32'(ram_addr), 32'h5555);
      tick();
    end
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    tick(); tick();

    // Simultaneous write and read strobes: write wins, no overrun
    spi_wr = 1'b1; spi_rd = 1'b1; spi_addr = 16'h4300; spi_wdata = 8'h33;
    we_cnt = 0;
    tick(); spi_wr = 1'b0; spi_rd = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (spi_rvalid) we_cnt++;
      tick();
    end
    check("both_rvalid_count", 32'(we_cnt), 32'd0);
    check("both_overrun",      32'(spi_overrun), 32'd0);
    check("both_mem",          32'(mem[16'h4300]), 32'h33);

    // Overrun: second strobe while busy is dropped and flagged
    spi_wr = 1'b1; spi_addr = 16'h4100; spi_wdata = 8'h11;
    tick(); spi_wr = 1'b0;
    tick();
    spi_wr = 1'b1; spi_addr = 16'h4200; spi_wdata = 8'h22;
    tick(); spi_wr = 1'b0;
    check("ovr_flag", 32'(spi_overrun), 32'd1);
    for (int c = 0; c < 6; c++) tick();
    check("ovr_first_mem",  32'(mem[16'h4100]), 32'h11);
    check("ovr_second_mem", 32'(mem[16'h4200]), 32'h99);
    check("ovr_sticky",     32'(spi_overrun), 32'd1);

    // CPU holds the bus, then an SPI write arrives
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 16'h6000;
    tick();
    spi_wr = 1'b1; spi_addr = 16'h4400; spi_wdata = 8'h44;
    tick(); spi_wr = 1'b0;
`ifdef RAM_ARB_WAIT_EN
    for (int c = 1; c < 8; c++) begin
      check("stv_wait_hi", 32'(cpu_wait_n), 32'd1);
      tick();
    end
    check("stv_c8_wait", 32'(cpu_wait_n), 32'd0);
    tick();
    check("stv_c9_we",   32'(ram_we), 32'd1);
    check("stv_c9_addr", 32'(ram_addr), 32'h4400);
    check("stv_c9_din",  32'(ram_din), 32'h44);
    tick();
    check("stv_c10_wait", 32'(cpu_wait_n), 32'd0);
    check("stv_c10_addr", 32'(ram_addr), 32'h6000);
    tick();
    check("stv_c11_wait", 32'(cpu_wait_n), 32'd1);
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    tick(); tick();
`else
    we_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (ram_we) we_cnt++;
      check("hold_wait_n", 32'(cpu_wait_n), 32'd1);
      tick();
    end
    check("hold_we_count", 32'(we_cnt), 32'd0);
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    for (int c = 0; c < 4; c++) tick();
`endif
    check("hold_mem", 32'(mem[16'h4400]), 32'h44);

    // Reset mid-request drops the buffered write and clears overrun
    spi_wr = 1'b1; spi_addr = 16'h4500; spi_wdata = 8'h55;
    tick(); spi_wr = 1'b0;
    check("mid_busy", 32'(spi_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy",    32'(spi_busy), 32'd0);
    check("mid_rst_overrun", 32'(spi_overrun), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("mid_mem", 32'(mem[16'h4500]), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
